// File: rtl/fifo_pkg.sv
// Shared helpers and constants for the synchronous FIFO family.
package fifo_pkg;

  localparam int unsigned FIFO_MODE_STD  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  // Read/write pointers carry one extra wrap bit above the address.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port RAM: synchronous write, registered read, single clock.
// The read register resets to zero so it can drive the FIFO output directly.
module fifo_ram_sdp
  import fifo_pkg::*;
#(
  parameter int unsigned Width = 9,
  parameter int unsigned Depth = 512
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      WrEn,
  input  logic [clog2(Depth)-1:0]   WrAddr,
  input  logic [Width-1:0]          WrData,
  input  logic                      RdEn,
  input  logic [clog2(Depth)-1:0]   RdAddr,
  output logic [Width-1:0]          RdData
);

  logic [Width-1:0] mem [Depth];

  // Write port.
  always_ff @(posedge Clk) begin
    if (WrEn) mem[WrAddr] <= WrData;
  end

  // Registered read port; holds its value between reads.
  always_ff @(posedge Clk) begin
    if (Reset)     RdData <= '0;
    else if (RdEn) RdData <= mem[RdAddr];
  end

endmodule

// File: rtl/base_fifo_sync.sv
// Single-clock FIFO with standard or first-word-fall-through read mode,
// exact data count, programmable thresholds and sticky error flags.
// Optional macro FIFO_HWM_EN adds the HighWater output.
module base_fifo_sync
  import fifo_pkg::*;
#(
  parameter int unsigned Width          = 9,
  parameter int unsigned Depth          = 512,
  parameter int unsigned FirstWordFall  = FIFO_MODE_STD,
  parameter int unsigned ProgEmptyValue = 10,
  parameter int unsigned ProgFullValue  = 14,
  parameter int unsigned DataCountWidth = 10
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Write,
  input  logic [Width-1:0]          Din,
  input  logic                      Read,
  output logic [Width-1:0]          Dout,
  output logic                      Valid,
  output logic                      Empty,
  output logic                      Full,
  output logic                      ProgEmpty,
  output logic                      ProgFull,
  output logic [DataCountWidth-1:0] DataCount,
  input  logic                      ClearErr,
  output logic                      Overflow,
  output logic                      Underflow
`ifdef FIFO_HWM_EN
  ,
  output logic [DataCountWidth-1:0] HighWater
`endif
);

  localparam int unsigned AW   = clog2(Depth);
  localparam int unsigned PW   = ptr_width(Depth);
  localparam bit          FWFT = (FirstWordFall == FIFO_MODE_FWFT);
  localparam logic [DataCountWidth-1:0] DEPTH_C = DataCountWidth'(Depth);
  localparam logic [DataCountWidth-1:0] PE_C    = DataCountWidth'(ProgEmptyValue);
  localparam logic [DataCountWidth-1:0] PF_C    = DataCountWidth'(ProgFullValue);

  logic [PW-1:0]             wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [DataCountWidth-1:0] count_q, count_nxt;
  logic                      valid_q, valid_nxt;
  logic                      empty_q, full_q, prog_empty_q, prog_full_q;
  logic                      ovf_q, udf_q;
  logic                      wr_ok, rd_pop, ram_rd, ram_has;
  logic                      ptr_eq_nxt, ptr_full_nxt;

  // Accept/pop decisions and next-state arithmetic.
  // In FWFT the RAM read register is the output stage: it is refilled
  // whenever it is empty or being popped and the RAM still holds words.
  always_comb begin
    wr_ok   = Write && !full_q;
    ram_has = (wr_ptr != rd_ptr);
    if (FWFT) begin
      rd_pop    = Read && valid_q;
      ram_rd    = ram_has && (!valid_q || rd_pop);
      valid_nxt = ram_rd || (valid_q && !rd_pop);
    end else begin
      rd_pop    = Read && !empty_q;
      ram_rd    = rd_pop;
      valid_nxt = rd_pop;
    end
    wr_ptr_nxt   = wr_ptr + PW'(wr_ok);
    rd_ptr_nxt   = rd_ptr + PW'(ram_rd);
    count_nxt    = count_q + DataCountWidth'(wr_ok) - DataCountWidth'(rd_pop);
    ptr_eq_nxt   = (wr_ptr_nxt == rd_ptr_nxt);
    ptr_full_nxt = (wr_ptr_nxt[PW-1] != rd_ptr_nxt[PW-1]) &&
                   (wr_ptr_nxt[PW-2:0] == rd_ptr_nxt[PW-2:0]);
  end

  // Pointers, count and status flags, all reflecting the post-edge state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      valid_q      <= 1'b0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      prog_empty_q <= 1'b1;
      prog_full_q  <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count_q      <= count_nxt;
      valid_q      <= valid_nxt;
      empty_q      <= FWFT ? !valid_nxt : ptr_eq_nxt;
      full_q       <= FWFT ? (count_nxt == DEPTH_C) : ptr_full_nxt;
      prog_empty_q <= (count_nxt <= PE_C);
      prog_full_q  <= (count_nxt >= PF_C);
    end
  end

  // Sticky error flags; a clear wins over a same-cycle set.
  always_ff @(posedge Clk) begin
    if (Reset || ClearErr) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (Write && full_q) ovf_q <= 1'b1;
      if (Read && empty_q) udf_q <= 1'b1;
    end
  end

`ifdef FIFO_HWM_EN
  logic [DataCountWidth-1:0] hwm_q;

  // Peak occupancy since reset or error clear, tracked alongside the count.
  always_ff @(posedge Clk) begin
    if (Reset)                  hwm_q <= '0;
    else if (ClearErr)          hwm_q <= count_nxt;
    else if (count_nxt > hwm_q) hwm_q <= count_nxt;
  end

  assign HighWater = hwm_q;
`endif

  fifo_ram_sdp #(
    .Width (Width),
    .Depth (Depth)
  ) u_ram (
    .Clk    (Clk),
    .Reset  (Reset),
    .WrEn   (wr_ok),
    .WrAddr (wr_ptr[AW-1:0]),
    .WrData (Din),
    .RdEn   (ram_rd),
    .RdAddr (rd_ptr[AW-1:0]),
    .RdData (Dout)
  );

  assign Valid     = valid_q;
  assign Empty     = empty_q;
  assign Full      = full_q;
  assign ProgEmpty = prog_empty_q;
  assign ProgFull  = prog_full_q;
  assign DataCount = count_q;
  assign Overflow  = ovf_q;
  assign Underflow = udf_q;

endmodule

// File: tb/tb_base_fifo_sync.sv
// Bench for base_fifo_sync: a standard-mode and an FWFT-mode instance share
// one input stream and are each compared against a queue-based model.
module tb_base_fifo_sync;

  localparam int DEPTH = 16;
  localparam int PEV   = 2;
  localparam int PFV   = 14;

  logic       clk = 1'b0;
  logic       rst, wr, rd, clr;
  logic [8:0] din;

  logic [8:0] s_dout, f_dout;
  logic       s_valid, s_empty, s_full, s_pe, s_pf, s_ovf, s_udf;
  logic       f_valid, f_empty, f_full, f_pe, f_pf, f_ovf, f_udf;
  logic [9:0] s_cnt, f_cnt;
`ifdef FIFO_HWM_EN
  logic [9:0] s_hwm, f_hwm;
`endif

  always #5 clk = ~clk;

  base_fifo_sync #(
    .Width(9), .Depth(DEPTH), .FirstWordFall(0),
    .ProgEmptyValue(PEV), .ProgFullValue(PFV), .DataCountWidth(10)
  ) u_std (
    .Clk(clk), .Reset(rst), .Write(wr), .Din(din), .Read(rd),
    .Dout(s_dout), .Valid(s_valid), .Empty(s_empty), .Full(s_full),
    .ProgEmpty(s_pe), .ProgFull(s_pf), .DataCount(s_cnt),
    .ClearErr(clr), .Overflow(s_ovf), .Underflow(s_udf)
`ifdef FIFO_HWM_EN
    , .HighWater(s_hwm)
`endif
  );

  base_fifo_sync #(
    .Width(9), .Depth(DEPTH), .FirstWordFall(1),
    .ProgEmptyValue(PEV), .ProgFullValue(PFV), .DataCountWidth(10)
  ) u_fwft (
    .Clk(clk), .Reset(rst), .Write(wr), .Din(din), .Read(rd),
    .Dout(f_dout), .Valid(f_valid), .Empty(f_empty), .Full(f_full),
    .ProgEmpty(f_pe), .ProgFull(f_pf), .DataCount(f_cnt),
    .ClearErr(clr), .Overflow(f_ovf), .Underflow(f_udf)
`ifdef FIFO_HWM_EN
    , .HighWater(f_hwm)
`endif
  );

  // Reference model state
  logic [8:0] sq[$];
  logic [8:0] fq[$];
  logic [8:0] ms_dout, mf_dout;
  bit         ms_valid, mf_valid, ms_ovf, ms_udf, mf_ovf, mf_udf;
  int         ms_hwm, mf_hwm;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one clock edge of FIFO rules to both models.
  task automatic model_edge();
    int cb;
    bit avail;
    if (rst) begin
      sq.delete(); fq.delete();
      ms_dout = '0; mf_dout = '0;
      ms_valid = 0; mf_valid = 0;
      ms_ovf = 0; ms_udf = 0; mf_ovf = 0; mf_udf = 0;
      ms_hwm = 0; mf_hwm = 0;
    end else begin
      // standard mode
      cb = sq.size();
      if (clr) begin ms_ovf = 0; ms_udf = 0; end
      else begin
        if (wr && cb == DEPTH) ms_ovf = 1;
        if (rd && cb == 0)     ms_udf = 1;
      end
      if (rd && cb > 0) begin ms_dout = sq.pop_front(); ms_valid = 1; end
      else ms_valid = 0;
      if (wr && cb < DEPTH) sq.push_back(din);
      if (clr) ms_hwm = sq.size();
      else if (sq.size() > ms_hwm) ms_hwm = sq.size();
      // FWFT mode: a word becomes visible one edge after it was stored
      cb = fq.size();
      if (clr) begin mf_ovf = 0; mf_udf = 0; end
      else begin
        if (wr && cb == DEPTH) mf_ovf = 1;
        if (rd && !mf_valid)   mf_udf = 1;
      end
      if (rd && mf_valid) void'(fq.pop_front());
      avail = (fq.size() > 0);
      mf_valid = avail;
      if (avail) mf_dout = fq[0];
      if (wr && cb < DEPTH) fq.push_back(din);
      if (clr) mf_hwm = fq.size();
      else if (fq.size() > mf_hwm) mf_hwm = fq.size();
    end
  endtask

  task automatic check_all();
    chk("std_dout",  32'(s_dout),  32'(ms_dout));
    chk("std_valid", 32'(s_valid), 32'(ms_valid));
    chk("std_empty", 32'(s_empty), 32'(sq.size() == 0));
    chk("std_full",  32'(s_full),  32'(sq.size() == DEPTH));
    chk("std_pe",    32'(s_pe),    32'(sq.size() <= PEV));
    chk("std_pf",    32'(s_pf),    32'(sq.size() >= PFV));
    chk("std_cnt",   32'(s_cnt),   32'(sq.size()));
    chk("std_ovf",   32'(s_ovf),   32'(ms_ovf));
    chk("std_udf",   32'(s_udf),   32'(ms_udf));
    chk("fw_dout",   32'(f_dout),  32'(mf_dout));
    chk("fw_valid",  32'(f_valid), 32'(mf_valid));
    chk("fw_empty",  32'(f_empty), 32'(!mf_valid));
    chk("fw_full",   32'(f_full),  32'(fq.size() == DEPTH));
    chk("fw_pe",     32'(f_pe),    32'(fq.size() <= PEV));
    chk("fw_pf",     32'(f_pf),    32'(fq.size() >= PFV));
    chk("fw_cnt",    32'(f_cnt),   32'(fq.size()));
    chk("fw_ovf",    32'(f_ovf),   32'(mf_ovf));
    chk("fw_udf",    32'(f_udf),   32'(mf_udf));
`ifdef FIFO_HWM_EN
    chk("std_hwm",   32'(s_hwm),   32'(ms_hwm));
    chk("fw_hwm",    32'(f_hwm),   32'(mf_hwm));
`endif
  endtask

  task automatic cycle(input bit r_st, input bit w, input logic [8:0] d,
                       input bit r, input bit c);
    rst = r_st; wr = w; din = d; rd = r; clr = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; clr = 1'b0; din = '0;

    // Reset state
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("rst_empty", 32'(s_empty), 32'd1);
    chk("rst_pe",    32'(f_pe),    32'd1);

    // Fill 0x001..0x010, then an overflowing write
    for (int i = 1; i <= 16; i++) begin
      cycle(0, 1, 9'(i), 0, 0);
      if (i == 13) chk("pf_before", 32'(s_pf), 32'd0);
      if (i == 14) chk("pf_at14",   32'(s_pf), 32'd1);
      if (i == 15) chk("full_at15", 32'(s_full), 32'd0);
    end
    chk("full_at16", 32'(s_full), 32'd1);
    chk("cnt_16",    32'(s_cnt),  32'd16);
    cycle(0, 1, 9'h1FF, 0, 0);
    chk("ovf_std", 32'(s_ovf), 32'd1);
    chk("ovf_fw",  32'(f_ovf), 32'd1);

    // Drain in order with one-cycle Valid pulses
    for (int i = 1; i <= 16; i++) begin
      cycle(0, 0, 0, 1, 0);
      chk("std_order",  32'(s_dout),  32'(i));
      chk("std_vpulse", 32'(s_valid), 32'd1);
    end
    cycle(0, 0, 0, 0, 0);
    chk("std_vdrop", 32'(s_valid), 32'd0);

    // FWFT single-word latency
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 9'h0A5, 0, 0);
    chk("fw_lat_n",   32'(f_valid), 32'd0);
    cycle(0, 0, 0, 0, 0);
    chk("fw_lat_n1v", 32'(f_valid), 32'd1);
    chk("fw_lat_n1d", 32'(f_dout),  32'h0A5);
    cycle(0, 0, 0, 1, 0);
    chk("fw_pop_empty", 32'(f_empty), 32'd1);
    chk("fw_pop_cnt",   32'(f_cnt),   32'd0);

    // Steady simultaneous read/write at depth 8, wrapping pointers
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 9'($urandom), 0, 0);
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      cycle(0, 1, 9'($urandom), 1, 0);
      chk("rw_cnt_std", 32'(s_cnt), 32'd8);
      chk("rw_cnt_fw",  32'(f_cnt), 32'd8);
    end

    // Underflow and clear priority
    for (int i = 0; i < 9; i++) cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    chk("udf_std",    32'(s_udf),   32'd1);
    chk("udf_vstd",   32'(s_valid), 32'd0);
    cycle(0, 0, 0, 1, 1);
    chk("udf_clr_std", 32'(s_udf), 32'd0);
    chk("udf_clr_fw",  32'(f_udf), 32'd0);

    // Reset mid-operation with Write and Read in the reset cycle
    for (int i = 0; i < 5; i++) cycle(0, 1, 9'(i + 32), 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 9'h055, 0, 0);
    cycle(1, 1, 9'h077, 1, 0);
    chk("rst_cnt",   32'(s_cnt),   32'd0);
    chk("rst_dout",  32'(s_dout),  32'd0);
    chk("rst_fdout", 32'(f_dout),  32'd0);
    chk("rst_fe",    32'(f_empty), 32'd1);

    // ProgEmpty boundary and high water
    for (int i = 0; i < 3; i++) cycle(0, 1, 9'(i + 64), 0, 0);
    chk("pe_at3", 32'(s_pe), 32'd0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    chk("pe_at2_std", 32'(s_pe), 32'd1);
    chk("pe_at2_fw",  32'(f_pe), 32'd1);
`ifdef FIFO_HWM_EN
    chk("hwm_3", 32'(s_hwm), 32'd3);
`endif

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 55, 9'($urandom),
            $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
